// File: rtl/nv_fifo_rwsthp_80x18_pkg.sv
// Shared NVDLA RAM parameters and pointer helpers for the 80x18 read-skid FIFO.
package nv_fifo_rwsthp_80x18_pkg;

  localparam int unsigned DEPTH      = 80;
  localparam int unsigned WIDTH      = 18;
  localparam int unsigned PTR_W      = 7;
  localparam int unsigned SKID_DEPTH = 3;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [1:0]       skid_idx_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic skid_idx_t skid_inc(input skid_idx_t p);
    return (p == skid_idx_t'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/nv_ram_rwsthp_80x18.sv
// 80x18 two-port RAM: registered read address on re, registered output on ore.
module nv_ram_rwsthp_80x18
  import nv_fifo_rwsthp_80x18_pkg::*;
(
  input  logic        clk,
  input  ptr_t        ra,
  input  logic        re,
  input  logic        ore,
  output data_t       dout,
  input  ptr_t        wa,
  input  logic        we,
  input  data_t       di,
  input  logic        byp_sel,
  input  data_t       dbyp,
  input  logic [31:0] pwrbus_ram_pd
);

  data_t mem [DEPTH];
  ptr_t  ra_q;
  data_t dout_q;
  logic  pwrbus_unused;

  // Power-bus controls only matter to the physical macro.
  assign pwrbus_unused = ^pwrbus_ram_pd;

  // NOTE: storage arrays get no reset; clearing them would cost a write port
  // per entry and nothing downstream depends on their initial contents.
  always_ff @(posedge clk) begin
    if (we)  mem[wa] <= di;
    if (re)  ra_q    <= ra;
    if (ore) dout_q  <= byp_sel ? dbyp : mem[ra_q];
  end

  assign dout = dout_q;

endmodule

// File: rtl/nv_fifo_rwsthp_80x18.sv
// 80-entry FIFO over a two-stage-read RAM, with a 3-entry credit-managed skid buffer.
module nv_fifo_rwsthp_80x18
  import nv_fifo_rwsthp_80x18_pkg::*;
(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [PTR_W-1:0] fifo_cnt
);

  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  ptr_t      fifo_cnt_q, fifo_cnt_d;
  logic      stage_a_q, stage_b_q;
  skid_idx_t skid_head_q, skid_head_d;
  skid_idx_t skid_tail_q, skid_tail_d;
  logic [1:0] skid_cnt_q, skid_cnt_d;
  data_t     skid_mem_q [SKID_DEPTH];
  data_t     ram_dout;

  logic       accept, issue, push, pop;
  logic [2:0] occ;
  logic [7:0] stored;

  assign pop    = rd_pvld && rd_prdy;
  assign accept = wr_pvld && wr_prdy;
  assign push   = stage_b_q;
  assign occ    = 3'(stage_a_q) + 3'(stage_b_q) + 3'(skid_cnt_q);

  // Capacity counts every entry the block holds, so a RAM slot is only
  // reused after its word has left the skid buffer.
  assign stored  = 8'(fifo_cnt_q) + 8'(occ);
  assign wr_prdy = stored < 8'(DEPTH);

  // fifo_cnt_q excludes this cycle's write, so a slot is never read as it is written.
  assign issue = (fifo_cnt_q != '0) && ((occ - 3'(pop)) < 3'(SKID_DEPTH));

  // NOTE: every combinational output takes a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    wr_ptr_d    = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = issue  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    skid_head_d = pop  ? skid_inc(skid_head_q) : skid_head_q;
    skid_tail_d = push ? skid_inc(skid_tail_q) : skid_tail_q;
    skid_cnt_d  = skid_cnt_q;
    case ({accept, issue})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({push, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 1'b1;
      2'b01:   skid_cnt_d = skid_cnt_q - 1'b1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      stage_a_q   <= 1'b0;
      stage_b_q   <= 1'b0;
      skid_head_q <= '0;
      skid_tail_q <= '0;
      skid_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      stage_a_q   <= issue;
      stage_b_q   <= stage_a_q;
      skid_head_q <= skid_head_d;
      skid_tail_q <= skid_tail_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) skid_mem_q[skid_tail_q] <= ram_dout;
  end

  assign rd_pvld  = skid_cnt_q != '0;
  assign rd_pd    = rd_pvld ? skid_mem_q[skid_head_q] : '0;
  assign fifo_cnt = fifo_cnt_q;

  nv_ram_rwsthp_80x18 u_ram (
    .clk           (nvdla_core_clk),
    .ra            (rd_ptr_q),
    .re            (issue),
    .ore           (stage_a_q),
    .dout          (ram_dout),
    .wa            (wr_ptr_q),
    .we            (accept),
    .di            (wr_pd),
    .byp_sel       (1'b0),
    .dbyp          ('0),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  skid_no_overflow: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    stage_b_q |-> (skid_cnt_q < 2'(SKID_DEPTH))
  );

endmodule
